// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
interface decode_stage_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int INSN_ADDR_WIDTH = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic [31:0]                in_insn;
    logic [INSN_ADDR_WIDTH-1:0] in_pc;

    logic                       out_valid;
    logic                       out_ready;
    logic [INSN_ADDR_WIDTH-1:0] out_pc;
    logic [4:0]                 out_rd;
    logic [4:0]                 out_rs1;
    logic [4:0]                 out_rs2;
    logic [DATA_WIDTH-1:0]      out_imm;
    logic [2:0]                 out_aluCode;
    logic                       out_isSubSra;
    logic [2:0]                 out_brCode;
    logic                       out_isBranch;
    logic                       out_isJump;
    logic                       out_isLoad;
    logic                       out_isStore;
    logic                       out_regWrEnable;
    logic                       out_isALUInConstant;
    logic                       out_illegal;

    // Upstream fetch and downstream execute side
    modport master (
        output in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
               out_aluCode, out_isSubSra, out_brCode, out_isBranch, out_isJump,
               out_isLoad, out_isStore, out_regWrEnable, out_isALUInConstant,
               out_illegal
    );

    // Decode stage side
    modport slave (
        input  in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
               out_aluCode, out_isSubSra, out_brCode, out_isBranch, out_isJump,
               out_isLoad, out_isStore, out_regWrEnable, out_isALUInConstant,
               out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode captured into a 2-entry skid buffer.
// Optional DECODE_ILLEGAL_CHECK_EN adds illegal-instruction detection.
module decode_stage #(
    parameter int DATA_WIDTH      = 32,
    parameter int INSN_ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          flush,
    decode_stage_if.slave bus
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} bufState_e;

    typedef struct packed {
        logic [INSN_ADDR_WIDTH-1:0] pc;
        logic [4:0]                 rd;
        logic [4:0]                 rs1;
        logic [4:0]                 rs2;
        logic [DATA_WIDTH-1:0]      imm;
        logic [2:0]                 aluCode;
        logic                       isSubSra;
        logic [2:0]                 brCode;
        logic                       isBranch;
        logic                       isJump;
        logic                       isLoad;
        logic                       isStore;
        logic                       regWrEnable;
        logic                       isALUInConstant;
        logic                       illegal;
    } payload_t;

    logic [31:0]           insn;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [31:0]           immFull;
    logic [DATA_WIDTH-1:0] immExt;
    payload_t              dec;
    payload_t              decFull;
    payload_t              mainQ;
    payload_t              skidQ;

    bufState_e state;
    bufState_e stateNext;
    logic      inReadyQ;
    logic      inXfer;
    logic      outXfer;
    logic      loadMain;
    logic      loadSkid;
    logic      moveSkid;

    assign insn   = bus.in_insn;
    assign opcode = insn[6:0];
    assign funct3 = insn[14:12];

    always_comb begin
        dec         = '0;
        dec.pc      = bus.in_pc;
        dec.rd      = insn[11:7];
        dec.rs1     = insn[19:15];
        dec.rs2     = insn[24:20];
        dec.brCode  = funct3;
        immFull     = {{20{insn[31]}}, insn[31:20]};
        case (opcode)
            OPC_OP: begin
                dec.aluCode     = funct3;
                dec.isSubSra    = insn[30];
                dec.regWrEnable = 1'b1;
            end
            OPC_OPIMM: begin
                dec.aluCode         = funct3;
                dec.isSubSra        = (funct3 == 3'b101) ? insn[30] : 1'b0;
                dec.regWrEnable     = 1'b1;
                dec.isALUInConstant = 1'b1;
            end
            OPC_LOAD: begin
                dec.isLoad          = 1'b1;
                dec.regWrEnable     = 1'b1;
                dec.isALUInConstant = 1'b1;
            end
            OPC_STORE: begin
                dec.isStore         = 1'b1;
                dec.isALUInConstant = 1'b1;
                immFull             = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            end
            OPC_BRANCH: begin
                dec.isBranch = 1'b1;
                immFull      = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.regWrEnable     = 1'b1;
                dec.isALUInConstant = 1'b1;
                immFull             = {insn[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec.isJump      = 1'b1;
                dec.regWrEnable = 1'b1;
                immFull         = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
            end
            OPC_JALR: begin
                dec.isJump          = 1'b1;
                dec.regWrEnable     = 1'b1;
                dec.isALUInConstant = 1'b1;
            end
            default: ;
        endcase
        if (dec.rd == 5'd0) begin
            dec.regWrEnable = 1'b0;
        end
`ifdef DECODE_ILLEGAL_CHECK_EN
        dec.illegal = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                       OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP})
                    || (insn[1:0] != 2'b11)
                    || (opcode == OPC_OP && insn[31:25] != 7'b0000000 && insn[31:25] != 7'b0100000)
                    || (opcode == OPC_BRANCH && (funct3 == 3'b010 || funct3 == 3'b011));
        if (dec.illegal) begin
            dec.isBranch        = 1'b0;
            dec.isJump          = 1'b0;
            dec.isLoad          = 1'b0;
            dec.isStore         = 1'b0;
            dec.regWrEnable     = 1'b0;
            dec.isALUInConstant = 1'b0;
        end
`else
        dec.illegal = 1'b0;
`endif
    end

    // Immediates are formed at 32 bits, then widened by sign or truncated.
    generate
        if (DATA_WIDTH > 32) begin : gImmWiden
            assign immExt = {{(DATA_WIDTH-32){immFull[31]}}, immFull};
        end else begin : gImmNarrow
            assign immExt = immFull[DATA_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        decFull     = dec;
        decFull.imm = immExt;
    end

    assign inXfer  = bus.in_valid & inReadyQ;
    assign outXfer = (state != EMPTY) & bus.out_ready;

    always_comb begin
        stateNext = state;
        loadMain  = 1'b0;
        loadSkid  = 1'b0;
        moveSkid  = 1'b0;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (inXfer) begin
                        stateNext = ONE;
                        loadMain  = 1'b1;
                    end
                end
                ONE: begin
                    if (inXfer && outXfer) begin
                        loadMain = 1'b1;
                    end else if (inXfer) begin
                        stateNext = TWO;
                        loadSkid  = 1'b1;
                    end else if (outXfer) begin
                        stateNext = EMPTY;
                    end
                end
                TWO: begin
                    if (outXfer) begin
                        stateNext = ONE;
                        moveSkid  = 1'b1;
                    end
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= EMPTY;
            inReadyQ <= 1'b1;
            mainQ    <= '0;
        end else begin
            state    <= stateNext;
            inReadyQ <= (stateNext != TWO);
            if (loadMain) begin
                mainQ <= decFull;
            end else if (moveSkid) begin
                mainQ <= skidQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (loadSkid) begin
            skidQ <= decFull;
        end
    end

    assign bus.in_ready            = inReadyQ;
    assign bus.out_valid           = (state != EMPTY);
    assign bus.out_pc              = mainQ.pc;
    assign bus.out_rd              = mainQ.rd;
    assign bus.out_rs1             = mainQ.rs1;
    assign bus.out_rs2             = mainQ.rs2;
    assign bus.out_imm             = mainQ.imm;
    assign bus.out_aluCode         = mainQ.aluCode;
    assign bus.out_isSubSra        = mainQ.isSubSra;
    assign bus.out_brCode          = mainQ.brCode;
    assign bus.out_isBranch        = mainQ.isBranch;
    assign bus.out_isJump          = mainQ.isJump;
    assign bus.out_isLoad          = mainQ.isLoad;
    assign bus.out_isStore         = mainQ.isStore;
    assign bus.out_regWrEnable     = mainQ.regWrEnable;
    assign bus.out_isALUInConstant = mainQ.isALUInConstant;
    assign bus.out_illegal         = mainQ.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised RV32I instruction decode stage. It takes fetched instruction words with a valid/ready handshake, produces fully sign-extended immediates and decoded control fields, and registers them behind a 2-entry skid buffer, so both ready paths are registered. It sits between fetch and execute in the pipelined core and replaces combinational field extraction and truncating immediate expansion.

## Interface
- `DATA_WIDTH`, 32: operand/immediate width; must be ≥ 12. Immediates sign-extend to 32 bits first, then sign-extend or truncate to this width.
- `INSN_ADDR_WIDTH`, 32: PC width carried alongside the instruction.
- `clk` in 1: clock; all state updates on the rising edge.
- `rstN` in 1: reset, asynchronous, active-low.
- `flush` in 1: discard all buffered entries and any same-cycle input.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: stage can accept; registered.
- `in_insn` in 32: instruction word.
- `in_pc` in INSN_ADDR_WIDTH: instruction PC.
- `out_valid` out 1: decoded entry valid.
- `out_ready` in 1: downstream accepts.
- `out_pc` out INSN_ADDR_WIDTH: PC of the entry.
- `out_rd`, `out_rs1`, `out_rs2` out 5 each: register numbers from bits [11:7], [19:15], [24:20].
- `out_imm` out DATA_WIDTH: sign-extended immediate for I/S/B/U/J format.
- `out_aluCode` out 3: ALU code.
- `out_isSubSra` out 1: SUB/SRA/SRAI selector.
- `out_brCode` out 3: branch code (funct3).
- `out_isBranch`, `out_isJump`, `out_isLoad`, `out_isStore`, `out_regWrEnable`, `out_isALUInConstant` out 1 each: control flags.
- `out_illegal` out 1: illegal instruction flag.

## Operation
- Buffer state machine with three states:
  - EMPTY: no entries held.
  - ONE: main register full.
  - TWO: main and skid registers full.
- An input transfer happens when `in_valid & in_ready`; an output transfer when `out_valid & out_ready`.
- State transitions:
  - EMPTY → ONE on an input transfer.
  - ONE → EMPTY on an output transfer with no input transfer.
  - ONE → TWO on an input transfer with no output transfer.
  - ONE stays ONE when both transfers happen; the main register reloads.
  - TWO → ONE on an output transfer; the skid entry moves to main.
- `in_ready` is registered and equals `state != TWO` for the next cycle. No input transfer is possible in TWO.
- `out_valid` = (state ≠ EMPTY). Outputs always come from the main register. Entries leave strictly in arrival order.
- `flush` has priority over everything. The next state is EMPTY, the same-cycle input is dropped, and `in_ready` is 1 in the following cycle.
- Decoding is combinational on `in_insn` and captured at input transfer.
- Immediates by format: I = insn[31:20]; S = {insn[31:25], insn[11:7]}; B = {insn[31], insn[7], insn[30:25], insn[11:8], 0}; U = {insn[31:12], 12'b0}; J = {insn[31], insn[19:12], insn[20], insn[30:21], 0}.
- `out_aluCode`:
  - funct3 for OP and OP_IMM.
  - ADD_SUB (000) for all other opcodes.
- `out_isSubSra`:
  - funct7[5] for OP.
  - For OP_IMM, funct7[5] only when funct3 = 101; otherwise 0.
- `out_regWrEnable` is set for OP, OP_IMM, LOAD, LUI, AUIPC, JAL and JALR, and is forced to 0 when rd = 0.
- `out_isALUInConstant` is set for OP_IMM, LOAD, STORE, LUI, AUIPC and JALR.
- `out_isJump` is set for JAL and JALR.
- Unknown opcode: all enable flags are 0 and the immediate is the I-format value.

## Timing
- Latency: an input accepted at edge N is visible on the outputs after edge N, i.e. cycle N+1.
- Throughput: one instruction per cycle while `out_ready` = 1.
- Reset values: state EMPTY, `in_ready` = 1, `out_valid` = 0, and all other outputs 0.
- Reset asserted mid-operation drops all entries asynchronously.
- The payload holds while `out_valid & ~out_ready`.
- Payload registers need no reset beyond the zero outputs shown above.

## Configuration
- `DECODE_ILLEGAL_CHECK_EN` defined:
  - `out_illegal` = 1 for an unknown opcode, insn[1:0] ≠ 11, OP with funct7 other than 0000000/0100000, or an undefined branch funct3 (010/011).
  - An illegal entry has every enable flag forced to 0.
- Not defined: `out_illegal` is constant 0 and no extra logic is built. Decoding is otherwise identical.

## Test plan
- `addi x1,x0,-1` (0xFFF00093), `out_ready` = 1 → one cycle later: `out_valid` = 1, rd = 1, `out_imm` = 0xFFFFFFFF, aluCode = 000, `out_regWrEnable` = 1, `out_isALUInConstant` = 1.
- `beq x0,x0,8` (0x00000463) → `out_isBranch` = 1, brCode = 000, `out_imm` = 8, `out_regWrEnable` = 0.
- `add x0,x1,x2` (0x00208033) → rs1 = 1, rs2 = 2, `out_regWrEnable` = 0. `sub x3,x1,x2` (0x402081B3) → `out_isSubSra` = 1.
- Back-to-back PCs 0, 4, 8, 12 with `out_ready` held 0 for 3 cycles → `in_ready` falls after PCs 0 and 4 are accepted. Then release → outputs in order 0, 4, 8, 12 with no loss or duplication.
- TWO state plus `flush` together with `in_valid` → next cycle `out_valid` = 0 and `in_ready` = 1; the flushed PC never appears.
- With the macro defined, 0x00000000 → `out_illegal` = 1 and all flags 0. Without the macro → `out_illegal` = 0.
